bcd_counter_n: RTL and testbench

BCD_COUNTER_N -- requirements
Module: bcd_counter_n

---
 rtl/bcd_counter_n.sv | 48 ++++
 tb/tb_bcd_counter_n.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_n.sv
// bcd_counter_n: cascadable N-decade up/down BCD counter with clear, load and wrap flag
module bcd_counter_n #(
  parameter int DIGITS  = 4,
  parameter bit UP_ONLY = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                en,
  input  logic                up_dn,
  output logic [4*DIGITS-1:0] q,
  output logic                co,
  output logic                wrap
);
  logic [4*DIGITS-1:0] cnt_q, cnt_d;
  logic                wrap_q;
  logic                up;
  logic [DIGITS:0]     all9, all0;
  assign up      = UP_ONLY | up_dn;
  assign all9[0] = 1'b1;
  assign all0[0] = 1'b1;
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    logic [3:0] d, ld, inc, dec;
    assign d  = cnt_q[4*k +: 4];
    assign ld = load_val[4*k +: 4] > 4'd9 ? 4'd0 : load_val[4*k +: 4];
    assign inc = d == 4'd9 ? 4'd0 : d + 4'd1;
    assign dec = d == 4'd0 ? 4'd9 : d - 4'd1;
    assign all9[k+1] = all9[k] & (d == 4'd9);
    assign all0[k+1] = all0[k] & (d == 4'd0);
    // all9[k]/all0[k] are the ripple enables from the lower decades
    assign cnt_d[4*k +: 4] = clr ? 4'd0 : load ? ld : !en ? d :
                             up ? (all9[k] ? inc : d) : (all0[k] ? dec : d);
  end
  assign co = en & ~clr & ~load & (up ? all9[DIGITS] : all0[DIGITS]);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= co;
    end
  end
  assign q    = cnt_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_bcd_counter_n.sv
// tb_bcd_counter_n: scoreboard bench for a 4-digit counter, a 2+2 cascade and a 1-digit up-only counter
module tb_bcd_counter_n;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clr = 1'b0, load = 1'b0, en = 1'b0, up_dn = 1'b1;
  logic [15:0] load_val = '0;
  logic [15:0] q;
  logic        co, wrap;
  logic [7:0]  lo_q, hi_q;
  logic        lo_co, hi_co, lo_wrap, hi_wrap;
  logic [3:0]  o_q;
  logic        o_co, o_wrap;
  int          checks = 0, errors = 0;

  typedef struct {
    logic        co;
    logic [15:0] q;
    logic        w;
    logic        co1;
    logic [3:0]  q1;
    logic        w1;
  } item_t;
  item_t sb[$];

  int m = 0, m1 = 0;

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(4)) dut (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .q(q), .co(co), .wrap(wrap));
  bcd_counter_n #(.DIGITS(2)) lo (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val[7:0]),
    .en(en), .up_dn(up_dn), .q(lo_q), .co(lo_co), .wrap(lo_wrap));
  bcd_counter_n #(.DIGITS(2)) hi (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val[15:8]),
    .en(lo_co), .up_dn(up_dn), .q(hi_q), .co(hi_co), .wrap(hi_wrap));
  bcd_counter_n #(.DIGITS(1), .UP_ONLY(1'b1)) one (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val[3:0]),
    .en(en), .up_dn(up_dn), .q(o_q), .co(o_co), .wrap(o_wrap));

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0, p = 1;
    for (int i = 0; i < 4; i++) begin
      int dg = int'((v >> (4 * i)) & 16'hF);
      r += (dg > 9 ? 0 : dg) * p;
      p *= 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      r |= 16'((v % 10) << (4 * i));
      v /= 10;
    end
    return r;
  endfunction

  task automatic step(input logic c, input logic l, input logic [15:0] lv, input logic e, input logic u);
    item_t it;
    int d1;
    @(negedge clk);
    clr = c; load = l; load_val = lv; en = e; up_dn = u;
    d1 = lv[3:0] > 4'd9 ? 0 : int'(lv[3:0]);
    it.co  = e & !c & !l & (u ? (m == 9999) : (m == 0));
    it.co1 = e & !c & !l & (m1 == 9);
    m  = c ? 0 : l ? bcd2int(lv) : !e ? m : u ? (m + 1) % 10000 : (m + 9999) % 10000;
    m1 = c ? 0 : l ? d1 : !e ? m1 : (m1 + 1) % 10;
    it.q  = int2bcd(m);
    it.w  = it.co;
    it.q1 = 4'(m1);
    it.w1 = it.co1;
    sb.push_back(it);
  endtask

  task automatic async_reset_check(input string n);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk({n, "_q"}, {16'h0, q}, 32'h0);
    chk({n, "_wrap"}, {31'h0, wrap}, 32'h0);
    chk({n, "_casc"}, {14'h0, hi_q, lo_q, hi_wrap}, 32'h0);
    chk({n, "_one"}, {27'h0, o_q, o_wrap}, 32'h0);
    clr = 1'b0; load = 1'b1; load_val = 16'h7777; en = 1'b1;
    m = 0; m1 = 0;
    @(posedge clk);
    #1;
    chk({n, "_held"}, {15'h0, q, wrap}, 32'h0);
    #1 reset = 1'b1;
  endtask

  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() != 0) begin
        it = sb.pop_front();
        chk("co", {31'h0, co}, {31'h0, it.co});
        chk("casc_co", {31'h0, hi_co}, {31'h0, it.co});
        chk("one_co", {31'h0, o_co}, {31'h0, it.co1});
        @(posedge clk);
        #1;
        chk("q", {16'h0, q}, {16'h0, it.q});
        chk("wrap", {31'h0, wrap}, {31'h0, it.w});
        chk("casc_q", {15'h0, hi_q, lo_q, hi_wrap}, {15'h0, it.q, it.w});
        chk("one_q", {27'h0, o_q, o_wrap}, {27'h0, it.q1, it.w1});
      end
    end
  end

  initial begin
    logic u;
    #2 reset = 1'b0;
    #1;
    chk("rst_q", {16'h0, q}, 32'h0);
    chk("rst_wrap", {31'h0, wrap}, 32'h0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    // full up sweep through 9999 and back to 0000
    for (int i = 0; i < 10001; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 16'hA9F3, 1'b0, 1'b1);
    step(1'b1, 1'b1, 16'h1234, 1'b1, 1'b1);
    step(1'b0, 1'b1, 16'h9999, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h1234, 1'b1, 1'b1);
    step(1'b0, 1'b1, 16'h9999, 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    u = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 37 == 0) u = ~u;
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3, 16'($urandom),
           $urandom_range(0, 99) < 30, u);
    end
    step(1'b0, 1'b1, 16'h4567, 1'b0, 1'b1);
    async_reset_check("rst_mid");
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 16'h9999, 1'b0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    async_reset_check("rst_wrap");
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("drain", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
